// File: rtl/hazard_controller.sv
// Load-use / redirect / memory-wait sequencer for the 5-stage RV32 pipe.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles / flush_events counters.
module hazard_controller #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic [3:0] ex_MemRead,
  input  logic       ex_redirect,
  input  logic       mem_access,
  input  logic       mem_ready,
  output logic       PC_write,
  output logic       IF_ID_write,
  output logic       IF_ID_flush,
  output logic       ID_EX_flush,
  output logic       pipe_freeze,
  output logic       control_MUX_select,
  output logic       mem_error
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] LU_STALL = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  localparam logic [2:0] LU_INIT = 3'(LOAD_USE_BUBBLES - 1);
  localparam logic [7:0] TMO     = 8'(MEM_TIMEOUT);

  logic [1:0] state_q, state_d;
  logic [2:0] lu_cnt_q, lu_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_error_q, mem_error_d;
  logic       luh, mw, stall;

  assign luh = (ex_MemRead != 4'd0) && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  assign mw  = mem_access && !mem_ready;

  always_comb begin
    PC_write           = 1'b1;
    IF_ID_write        = 1'b1;
    IF_ID_flush        = 1'b0;
    ID_EX_flush        = 1'b0;
    pipe_freeze        = 1'b0;
    control_MUX_select = 1'b0;
    stall              = 1'b0;
    state_d            = state_q;
    lu_cnt_d           = lu_cnt_q;
    wait_cnt_d         = wait_cnt_q;
    mem_error_d        = mem_error_q;
    if (mw) begin
      // Freeze takes priority; lu_cnt is left untouched so a stall resumes.
      pipe_freeze = 1'b1;
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      state_d     = MEM_WAIT;
      wait_cnt_d  = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
      if (wait_cnt_d >= TMO) mem_error_d = 1'b1;
    end else begin
      wait_cnt_d = 8'd0;
      if (ex_redirect) begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
        lu_cnt_d    = 3'd0;
        state_d     = RUN;
      end else if (state_q == LU_STALL) begin
        stall    = 1'b1;
        lu_cnt_d = (lu_cnt_q != 3'd0) ? lu_cnt_q - 3'd1 : 3'd0;
        if (lu_cnt_q <= 3'd1) state_d = RUN;
      end else if (state_q == MEM_WAIT && lu_cnt_q != 3'd0) begin
        // Resuming an interrupted load-use stall: keep the consumer held.
        stall   = 1'b1;
        state_d = LU_STALL;
      end else if (luh) begin
        stall = 1'b1;
        if (LOAD_USE_BUBBLES > 1) begin
          lu_cnt_d = LU_INIT;
          state_d  = LU_STALL;
        end else begin
          state_d = RUN;
        end
      end else begin
        state_d = RUN;
      end
    end
    if (stall) begin
      PC_write           = 1'b0;
      IF_ID_write        = 1'b0;
      control_MUX_select = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      lu_cnt_q    <= 3'd0;
      wait_cnt_q  <= 8'd0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lu_cnt_q    <= lu_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign mem_error = mem_error_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, flush_events_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      if (!PC_write)   stall_cycles_q <= stall_cycles_q + 32'd1;
      if (IF_ID_flush) flush_events_q <= flush_events_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench: instance a uses default parameters, instance b uses
// LOAD_USE_BUBBLES=3 / MEM_TIMEOUT=3; both share the same stimulus.
module tb_hazard_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, ex_redirect, mem_access, mem_ready;
  logic [3:0] ex_MemRead;

  logic a_pcw, a_ifw, a_iff, a_idf, a_frz, a_cms, a_err;
  logic b_pcw, b_ifw, b_iff, b_idf, b_frz, b_cms, b_err;
  logic [6:0] a_out, b_out;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] a_stall, a_flush, b_stall, b_flush;
`endif

  int errors = 0;
  int checks = 0;

  // Output vector order: {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush,
  //                       pipe_freeze, control_MUX_select, mem_error}
  localparam logic [6:0] RUNO   = 7'b1100000;
  localparam logic [6:0] STALL  = 7'b0000010;
  localparam logic [6:0] FREEZE = 7'b0000100;
  localparam logic [6:0] FLUSH  = 7'b1111000;
  localparam logic [6:0] ERR    = 7'b0000001;

  assign a_out = {a_pcw, a_ifw, a_iff, a_idf, a_frz, a_cms, a_err};
  assign b_out = {b_pcw, b_ifw, b_iff, b_idf, b_frz, b_cms, b_err};

  always #5 clk = ~clk;

  hazard_controller u_a (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_MemRead(ex_MemRead),
    .ex_redirect(ex_redirect), .mem_access(mem_access), .mem_ready(mem_ready),
    .PC_write(a_pcw), .IF_ID_write(a_ifw), .IF_ID_flush(a_iff),
    .ID_EX_flush(a_idf), .pipe_freeze(a_frz), .control_MUX_select(a_cms),
    .mem_error(a_err)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(a_stall), .flush_events(a_flush)
`endif
  );

  hazard_controller #(.LOAD_USE_BUBBLES(3), .MEM_TIMEOUT(3)) u_b (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_MemRead(ex_MemRead),
    .ex_redirect(ex_redirect), .mem_access(mem_access), .mem_ready(mem_ready),
    .PC_write(b_pcw), .IF_ID_write(b_ifw), .IF_ID_flush(b_iff),
    .ID_EX_flush(b_idf), .pipe_freeze(b_frz), .control_MUX_select(b_cms),
    .mem_error(b_err)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(b_stall), .flush_events(b_flush)
`endif
  );

  task automatic idle();
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_uses_rs2 = 1'b0; ex_rd = 5'd0;
    ex_MemRead = 4'd0; ex_redirect = 1'b0; mem_access = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic load_use();
    ex_MemRead = 4'h2; ex_rd = 5'd5; id_rs1 = 5'd5;
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    #2;
    checks++; if (a_out !== RUNO) begin errors++; $display("FAIL reset_a got=%b exp=%b", a_out, RUNO); end
    checks++; if (b_out !== RUNO) begin errors++; $display("FAIL reset_b got=%b exp=%b", b_out, RUNO); end
`ifdef HAZARD_PERF_CNT_EN
    checks++; if (b_stall !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", b_stall); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_no_hazard();
    for (int i = 0; i < 3; i++) begin
      cyc(); idle(); #1;
      checks++; if (a_out !== RUNO) begin errors++; $display("FAIL idle_a[%0d] got=%b exp=%b", i, a_out, RUNO); end
      checks++; if (b_out !== RUNO) begin errors++; $display("FAIL idle_b[%0d] got=%b exp=%b", i, b_out, RUNO); end
    end
  endtask

  task automatic test_load_use();
    logic [6:0] exp_b [4];
    exp_b = '{STALL, STALL, STALL, RUNO};
    cyc(); load_use(); #1;
    checks++; if (a_out !== STALL) begin errors++; $display("FAIL lu_a got=%b exp=%b", a_out, STALL); end
    checks++; if (b_out !== exp_b[0]) begin errors++; $display("FAIL lu_b[0] got=%b exp=%b", b_out, exp_b[0]); end
    for (int i = 1; i < 4; i++) begin
      cyc(); idle(); #1;
      checks++; if (a_out !== RUNO) begin errors++; $display("FAIL lu_a_after[%0d] got=%b exp=%b", i, a_out, RUNO); end
      checks++; if (b_out !== exp_b[i]) begin errors++; $display("FAIL lu_b[%0d] got=%b exp=%b", i, b_out, exp_b[i]); end
    end
    // rs2 match only counts when the instruction reads rs2
    cyc(); idle(); ex_MemRead = 4'h2; ex_rd = 5'd7; id_rs2 = 5'd7; #1;
    checks++; if (a_out !== RUNO) begin errors++; $display("FAIL rs2_unused got=%b exp=%b", a_out, RUNO); end
    id_uses_rs2 = 1'b1; #1;
    checks++; if (a_out !== STALL) begin errors++; $display("FAIL rs2_used got=%b exp=%b", a_out, STALL); end
    for (int i = 0; i < 3; i++) begin cyc(); idle(); end
    #1;
    checks++; if (b_out !== RUNO) begin errors++; $display("FAIL rs2_b_done got=%b exp=%b", b_out, RUNO); end
    // x0 never hazards
    cyc(); idle(); ex_MemRead = 4'h2; ex_rd = 5'd0; id_rs1 = 5'd0; #1;
    checks++; if (a_out !== RUNO) begin errors++; $display("FAIL x0_a got=%b exp=%b", a_out, RUNO); end
    checks++; if (b_out !== RUNO) begin errors++; $display("FAIL x0_b got=%b exp=%b", b_out, RUNO); end
  endtask

  task automatic test_redirect();
    cyc(); idle(); load_use(); ex_redirect = 1'b1; #1;
    checks++; if (a_out !== FLUSH) begin errors++; $display("FAIL redir_a got=%b exp=%b", a_out, FLUSH); end
    checks++; if (b_out !== FLUSH) begin errors++; $display("FAIL redir_b got=%b exp=%b", b_out, FLUSH); end
    cyc(); idle(); #1;
    checks++; if (b_out !== RUNO) begin errors++; $display("FAIL redir_b_next got=%b exp=%b", b_out, RUNO); end
    // redirect during LU_STALL cancels the remaining bubbles
    cyc(); load_use(); #1;
    cyc(); idle(); ex_redirect = 1'b1; #1;
    checks++; if (b_out !== FLUSH) begin errors++; $display("FAIL redir_stall_b got=%b exp=%b", b_out, FLUSH); end
    cyc(); idle(); #1;
    checks++; if (b_out !== RUNO) begin errors++; $display("FAIL redir_cancel_b got=%b exp=%b", b_out, RUNO); end
  endtask

  task automatic test_mem_wait();
    logic [6:0] exp_b [4];
    exp_b = '{FREEZE, FREEZE, FREEZE, FREEZE | ERR};
    for (int i = 0; i < 4; i++) begin
      cyc(); idle(); mem_access = 1'b1; mem_ready = 1'b0;
      if (i == 1) ex_redirect = 1'b1;
      #1;
      checks++; if (a_out !== FREEZE) begin errors++; $display("FAIL wait_a[%0d] got=%b exp=%b", i, a_out, FREEZE); end
      checks++; if (b_out !== exp_b[i]) begin errors++; $display("FAIL wait_b[%0d] got=%b exp=%b", i, b_out, exp_b[i]); end
    end
    cyc(); idle(); mem_access = 1'b1; mem_ready = 1'b1; #1;
    checks++; if (a_out !== RUNO) begin errors++; $display("FAIL resume_a got=%b exp=%b", a_out, RUNO); end
    checks++; if (b_out !== (RUNO | ERR)) begin errors++; $display("FAIL resume_b got=%b exp=%b", b_out, RUNO | ERR); end
    cyc(); idle(); #1;
    checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", b_err); end
    reset = 1'b1; #1;
    checks++; if (b_out !== RUNO) begin errors++; $display("FAIL err_reset got=%b exp=%b", b_out, RUNO); end
    reset = 1'b0;
  endtask

  task automatic test_reset_in_stall();
    cyc(); idle(); load_use(); #1;
    cyc(); idle(); #1;
    checks++; if (b_out !== STALL) begin errors++; $display("FAIL pre_abort_b got=%b exp=%b", b_out, STALL); end
    reset = 1'b1; #1;
    checks++; if (b_out !== RUNO) begin errors++; $display("FAIL abort_b got=%b exp=%b", b_out, RUNO); end
    reset = 1'b0;
    cyc(); #1;
    checks++; if (b_out !== RUNO) begin errors++; $display("FAIL post_abort_b got=%b exp=%b", b_out, RUNO); end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    reset = 1'b1; #1; reset = 1'b0;
    checks++; if (b_stall !== 32'd0) begin errors++; $display("FAIL perf_zero got=%0d exp=0", b_stall); end
    cyc(); idle(); load_use(); #1;
    for (int i = 0; i < 4; i++) begin cyc(); idle(); end
    #1;
    checks++; if (b_stall !== 32'd3) begin errors++; $display("FAIL perf_b_stall got=%0d exp=3", b_stall); end
    checks++; if (a_stall !== 32'd1) begin errors++; $display("FAIL perf_a_stall got=%0d exp=1", a_stall); end
    cyc(); idle(); ex_redirect = 1'b1; #1;
    cyc(); idle(); #1;
    checks++; if (a_flush !== 32'd1) begin errors++; $display("FAIL perf_flush got=%0d exp=1", a_flush); end
  endtask
`endif

  initial begin
    test_reset();
    test_no_hazard();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_reset_in_stall();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
